wb_retire_buf: RTL

- Parametrised successor to the write-back stage. Accepts results from the Memory stage on a valid/rdy handshake and holds them in a DEPTH-entry in-order retire buffer.
- Drains up to WR_PORTS results per cycle to a multi-ported GPR file.
- Provides RD_QRY forwarding lookups against buffered, not-yet-written results.
- Sits between the Memory stage and the GPR file.

---
 rtl/wb_retire_buf_pkg.sv | 19 +
 rtl/wb_retire_buf_fwd_match.sv | 41 ++++
 rtl/wb_retire_buf.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wb_retire_buf_pkg.sv
// Shared defaults and entry tag type for the write-back retire buffer.
package wb_retire_buf_pkg;

  localparam int WB_XLEN     = 32;
  localparam int WB_DEPTH    = 4;
  localparam int WB_WR_PORTS = 2;
  localparam int WB_RD_QRY   = 2;

  typedef struct packed {
    logic       rd_wr;
    logic [4:0] rd_addr;
  } wb_tag_t;

  // x0 is hard-wired, so a write to it is never a real GPR update
  function automatic logic tag_writes(input wb_tag_t tag);
    return tag.rd_wr & (tag.rd_addr != 5'd0);
  endfunction

endpackage

// File: rtl/wb_retire_buf_fwd_match.sv
// Combinational youngest-match search over the retire buffer for one forwarding query.
module wb_retire_buf_fwd_match
  import wb_retire_buf_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic [DEPTH-1:0]         vld,
  input  wb_tag_t                  tag  [DEPTH],
  input  logic [XLEN-1:0]          data [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] tail,
  input  logic [4:0]               addr,
  output logic                     hit,
  output logic [XLEN-1:0]          hit_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx_s;
  logic             match_s;

  // Walk oldest to youngest so the last match seen is the youngest one
  always_comb begin
    hit      = 1'b0;
    hit_data = {XLEN{1'b0}};
    idx_s    = tail;
    match_s  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx_s   = tail - PTR_W'(k);
      match_s = vld[idx_s] & tag[idx_s].rd_wr & (tag[idx_s].rd_addr == addr) & (addr != 5'd0);
      if (match_s) begin
        hit      = 1'b1;
        hit_data = data[idx_s];
      end else begin
        hit      = hit;
        hit_data = hit_data;
      end
    end
  end

endmodule

// File: rtl/wb_retire_buf.sv
// In-order write-back retire buffer draining up to WR_PORTS results per cycle to the GPR file.
// Optional retire counter output retire_cnt is built when WB_RETIRE_CNT_EN is defined.
module wb_retire_buf
  import wb_retire_buf_pkg::*;
#(
  parameter int XLEN     = WB_XLEN,
  parameter int DEPTH    = WB_DEPTH,
  parameter int WR_PORTS = WB_WR_PORTS,
  parameter int RD_QRY   = WB_RD_QRY
) (
  input  logic                           clk_in,
  input  logic                           reset_in,
  input  logic                           cpu_halt,
  input  logic                           in_valid,
  output logic                           in_rdy,
  input  logic                           in_Rd_wr,
  input  logic [4:0]                     in_Rd_addr,
  input  logic [XLEN-1:0]                in_Rd_data,
  output logic [WR_PORTS-1:0]            gpr_wr,
  output logic [5*WR_PORTS-1:0]          gpr_addr,
  output logic [XLEN*WR_PORTS-1:0]       gpr_data,
  input  logic [5*RD_QRY-1:0]            qry_addr,
  output logic [RD_QRY-1:0]              qry_hit,
  output logic [XLEN*RD_QRY-1:0]         qry_data,
  output logic [$clog2(WR_PORTS+1)-1:0]  retire_inc,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic                           empty
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]                    retire_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int INC_W = $clog2(WR_PORTS + 1);
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] PORTS_OCC = OCC_W'(WR_PORTS);

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [OCC_W-1:0] occ_r;
  logic [DEPTH-1:0] vld_r;
  wb_tag_t          tag_r  [DEPTH];
  logic [XLEN-1:0]  data_r [DEPTH];

  logic                push_s;
  logic [INC_W-1:0]    drain_n_s;
  logic [PTR_W-1:0]    port_idx_s [WR_PORTS];
  logic [WR_PORTS-1:0] port_act_s;

  // Full check uses registered occupancy only, keeping drain logic off the ready path
  assign in_rdy     = reset_in & ~cpu_halt & (occ_r != FULL_OCC);
  assign push_s     = in_valid & in_rdy;
  assign retire_inc = drain_n_s;
  assign occupancy  = occ_r;
  assign empty      = (occ_r == {OCC_W{1'b0}});

  // Drain count is min(occupancy, WR_PORTS); port i maps to entry head+i
  always_comb begin
    port_act_s = {WR_PORTS{1'b0}};
    if (occ_r < PORTS_OCC) begin
      drain_n_s = INC_W'(occ_r);
    end else begin
      drain_n_s = INC_W'(WR_PORTS);
    end
    for (int i = 0; i < WR_PORTS; i++) begin
      port_idx_s[i] = head_r + PTR_W'(i);
      port_act_s[i] = (INC_W'(i) < drain_n_s);
    end
  end

  // GPR write ports; within a drain group an older write is masked by a younger one to the same Rd
  always_comb begin
    gpr_wr   = {WR_PORTS{1'b0}};
    gpr_addr = {(5*WR_PORTS){1'b0}};
    gpr_data = {(XLEN*WR_PORTS){1'b0}};
    for (int i = 0; i < WR_PORTS; i++) begin
      if (port_act_s[i]) begin
        gpr_addr[5*i +: 5]       = tag_r[port_idx_s[i]].rd_addr;
        gpr_data[XLEN*i +: XLEN] = data_r[port_idx_s[i]];
        gpr_wr[i]                = tag_writes(tag_r[port_idx_s[i]]);
        for (int j = i + 1; j < WR_PORTS; j++) begin
          if (port_act_s[j] && tag_writes(tag_r[port_idx_s[j]]) &&
              (tag_r[port_idx_s[j]].rd_addr == tag_r[port_idx_s[i]].rd_addr)) begin
            gpr_wr[i] = 1'b0;
          end else begin
            gpr_wr[i] = gpr_wr[i];
          end
        end
      end else begin
        gpr_wr[i] = 1'b0;
      end
    end
  end

  // Pointer, occupancy and valid-bit state; a push never lands on a slot being drained
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      occ_r  <= {OCC_W{1'b0}};
      vld_r  <= {DEPTH{1'b0}};
    end else begin
      head_r <= head_r + PTR_W'(drain_n_s);
      occ_r  <= occ_r + OCC_W'(push_s) - OCC_W'(drain_n_s);
      for (int i = 0; i < WR_PORTS; i++) begin
        if (port_act_s[i]) begin
          vld_r[port_idx_s[i]] <= 1'b0;
        end
      end
      if (push_s) begin
        vld_r[tail_r] <= 1'b1;
        tail_r        <= tail_r + PTR_W'(1);
      end
    end
  end

  // Entry payload storage written at tail on push
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int e = 0; e < DEPTH; e++) begin
        tag_r[e]  <= '{rd_wr: 1'b0, rd_addr: 5'd0};
        data_r[e] <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      tag_r[tail_r]  <= '{rd_wr: in_Rd_wr, rd_addr: in_Rd_addr};
      data_r[tail_r] <= in_Rd_data;
    end
  end

  for (genvar q = 0; q < RD_QRY; q++) begin : g_qry
    wb_retire_buf_fwd_match #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
    ) u_fwd (
      .vld      (vld_r),
      .tag      (tag_r),
      .data     (data_r),
      .tail     (tail_r),
      .addr     (qry_addr[5*q +: 5]),
      .hit      (qry_hit[q]),
      .hit_data (qry_data[XLEN*q +: XLEN])
    );
  end

`ifdef WB_RETIRE_CNT_EN
  // Retired-instruction counter feeding minstret; wraps naturally at 2^64
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      retire_cnt <= 64'd0;
    end else begin
      retire_cnt <= retire_cnt + 64'(retire_inc);
    end
  end
`endif

endmodule
